// File: rtl/seg_scan_4dig.sv
// seg_scan_4dig: 4-digit multiplexed common-anode 7-segment driver with frame-aligned shadow load.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_4dig #(
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 500,
    parameter int DP_POS   = 2
) (
    input  logic        sys_clk50m,
    input  logic        sys_rst,
    input  logic [15:0] data,
    output logic [7:0]  seg,
    output logic [3:0]  sel,
    output logic        frame
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);
    localparam logic [2:0] DPP = 3'(DP_POS);
    logic [CW-1:0] cnt;
    logic [1:0]    idx;
    logic [15:0]   shd;
    logic [3:0]    nib;
    logic [6:0]    dec;
    logic          wrap, load, dark, blank, dp_on;
    logic [7:0]    seg_n;
    logic [3:0]    sel_n;
    assign wrap = cnt == CMAX;
    assign load = wrap && idx == 2'd3;
    assign nib = shd[4*idx +: 4];
    if (GUARD == 0) begin : g_no_guard
        assign dark = 1'b0;
    end else begin : g_guard
        assign dark = cnt < CW'(GUARD);
    end
`ifdef SEG_LZB_EN
    localparam int LIM = DP_POS <= 3 ? DP_POS : 0;
    localparam logic [3:0] SHOWN = 4'((1 << (LIM + 1)) - 1);
    logic [3:0] z;
    // z[k]: nibbles 3..k are all zero
    assign z = {shd[15:12] == 4'h0, shd[15:8] == 8'h0, shd[15:4] == 12'h0, shd == 16'h0};
    assign blank = !SHOWN[idx] && z[idx];
`else
    assign blank = 1'b0;
`endif
    always_comb begin
        dec = 7'h3F;
        case (nib)
            4'd0: dec = 7'h40;
            4'd1: dec = 7'h79;
            4'd2: dec = 7'h24;
            4'd3: dec = 7'h30;
            4'd4: dec = 7'h19;
            4'd5: dec = 7'h12;
            4'd6: dec = 7'h02;
            4'd7: dec = 7'h78;
            4'd8: dec = 7'h00;
            4'd9: dec = 7'h10;
            default: dec = 7'h3F;
        endcase
    end
    // the dash glyph never carries the decimal point
    assign dp_on = {1'b0, idx} == DPP && nib <= 4'd9;
    assign seg_n = (dark || blank) ? 8'hFF : {!dp_on, dec};
    assign sel_n = dark ? 4'hF : ~(4'b0001 << idx);
    always_ff @(posedge sys_clk50m) begin
        if (sys_rst) begin
            cnt   <= '0;
            idx   <= 2'd0;
            shd   <= 16'h0000;
            seg   <= 8'hFF;
            sel   <= 4'hF;
            frame <= 1'b0;
        end else begin
            cnt   <= wrap ? '0 : cnt + 1'b1;
            idx   <= wrap ? idx + 2'd1 : idx;
            shd   <= load ? data : shd;
            frame <= load;
            seg   <= seg_n;
            sel   <= sel_n;
        end
    end
endmodule
